// File: rtl/inst_buffer_queue_pkg.sv
// Shared types and sizing for the instruction buffer queue between Decode and Rename.
// Widths are derived here so every file agrees on pointer, count and offset sizes.
package inst_buffer_queue_pkg;

   localparam int DECODE_WIDTH     = 4;
   localparam int DISPATCH_WIDTH   = 4;
   localparam int INST_QUEUE_DEPTH = 32;
   localparam int REN_PKT_SIZE     = 32;

   localparam int PTR_W = $clog2(INST_QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OFF_W = $clog2(DECODE_WIDTH + 1);

   typedef struct packed {
      logic                    valid;
      logic [REN_PKT_SIZE-1:0] payload;
   } renPkt;

endpackage

// File: rtl/inst_buffer_queue_if.sv
// Decode-side write group and rename-side bundle of the instruction buffer queue.
// The queue is the slave; whoever drives decode and backend control is the master.
interface inst_buffer_queue_if;
   import inst_buffer_queue_pkg::*;

   logic                                flush_i;
   logic                                stall_i;
   logic                                decodeReady_i;
   renPkt [DECODE_WIDTH-1:0]            decodedPacket_i;
   renPkt [DISPATCH_WIDTH-1:0]          renPacket_o;
   logic                                instBufferReady_o;
   logic                                stallFetch_o;
   logic [CNT_W-1:0]                    instCount_o;

   modport master (
      output flush_i, stall_i, decodeReady_i, decodedPacket_i,
      input  renPacket_o, instBufferReady_o, stallFetch_o, instCount_o
   );

   modport slave (
      input  flush_i, stall_i, decodeReady_i, decodedPacket_i,
      output renPacket_o, instBufferReady_o, stallFetch_o, instCount_o
   );

endinterface

// File: rtl/inst_queue_compact.sv
// Prefix-sum over decode slot valid bits: slot k is written at tail + (valid slots below k),
// so a sparse decode group lands densely in program order.
module inst_queue_compact
   import inst_buffer_queue_pkg::*;
(
   input  logic [DECODE_WIDTH-1:0]            i_valid,
   output logic [DECODE_WIDTH-1:0][OFF_W-1:0] o_offset,
   output logic [OFF_W-1:0]                   o_nEnq
);

   always_comb begin
      logic [OFF_W-1:0] runSum;
      runSum   = '0;
      o_offset = '0;
      for (int k = 0; k < DECODE_WIDTH; k++) begin
         o_offset[k] = runSum;
         runSum      = runSum + OFF_W'(i_valid[k]);
      end
      o_nEnq = runSum;
   end

endmodule

// File: rtl/inst_buffer_queue.sv
// Circular instruction queue: compacts decode groups in program order and issues only
// full DISPATCH_WIDTH bundles to Rename; stalls fetch when a full group might not fit.
module inst_buffer_queue
   import inst_buffer_queue_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   inst_buffer_queue_if.slave bus
);

   logic [PTR_W-1:0]                   r_head;
   logic [PTR_W-1:0]                   r_tail;
   logic [CNT_W-1:0]                   r_count;
   renPkt                              r_entries [INST_QUEUE_DEPTH];

   logic [DECODE_WIDTH-1:0]            w_slotValid;
   logic [DECODE_WIDTH-1:0][OFF_W-1:0] w_offset;
   logic [OFF_W-1:0]                   w_nEnq;
   logic                               w_ready;
   logic                               w_stallFetch;
   logic                               w_enq;
   logic                               w_fire;
   logic [CNT_W-1:0]                   w_enqCount;
   logic [CNT_W-1:0]                   w_deqCount;

   always_comb begin
      w_slotValid = '0;
      for (int k = 0; k < DECODE_WIDTH; k++) begin
         w_slotValid[k] = bus.decodedPacket_i[k].valid;
      end
   end

   inst_queue_compact u_compact (
      .i_valid  (w_slotValid),
      .o_offset (w_offset),
      .o_nEnq   (w_nEnq)
   );

   // Both flags come from the registered count only; same-cycle dequeue is ignored.
   assign w_ready      = r_count >= CNT_W'(DISPATCH_WIDTH);
   assign w_stallFetch = r_count > CNT_W'(INST_QUEUE_DEPTH - DECODE_WIDTH);
   assign w_enq        = bus.decodeReady_i & ~w_stallFetch & ~bus.flush_i;
   assign w_fire       = w_ready & ~bus.stall_i & ~bus.flush_i;
   assign w_enqCount   = w_enq  ? CNT_W'(w_nEnq)         : '0;
   assign w_deqCount   = w_fire ? CNT_W'(DISPATCH_WIDTH) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (bus.flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_deqCount);
         r_tail  <= r_tail + PTR_W'(w_enqCount);
         r_count <= r_count + w_enqCount - w_deqCount;
      end
   end

   // Contents need no reset: nothing is visible unless count says it is live.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         for (int k = 0; k < DECODE_WIDTH; k++) begin
            if (w_slotValid[k]) begin
               r_entries[r_tail + PTR_W'(w_offset[k])] <= bus.decodedPacket_i[k];
            end
         end
      end
   end

   always_comb begin
      bus.renPacket_o = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         bus.renPacket_o[i]       = r_entries[r_head + PTR_W'(i)];
         bus.renPacket_o[i].valid = r_entries[r_head + PTR_W'(i)].valid & w_ready;
      end
   end

   assign bus.instBufferReady_o = w_ready;
   assign bus.stallFetch_o      = w_stallFetch;
   assign bus.instCount_o       = r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (r_count <= CNT_W'(INST_QUEUE_DEPTH));
         if (!bus.flush_i) begin
            assert ({1'b0, r_count} + {1'b0, w_enqCount} >= {1'b0, w_deqCount});
            assert ({1'b0, r_count} + {1'b0, w_enqCount} - {1'b0, w_deqCount}
                    <= (CNT_W+1)'(INST_QUEUE_DEPTH));
         end
      end
   end

endmodule

// File: tb/tb_inst_buffer_queue.sv
// Bench for inst_buffer_queue: directed decode groups feed a scoreboard of expected packets;
// a negedge monitor pops a bundle whenever the queue fires and checks order and valid gating.
module tb_inst_buffer_queue;
   import inst_buffer_queue_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   modelCount = 0;
   int   groupId = 0;
   renPkt expQ[$];

   always #5 clk = ~clk;

   inst_buffer_queue_if bus();

   inst_buffer_queue dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of stimulus, checks registered-count outputs, then advances the model.
   task automatic applyStimulus(input bit flush, input bit stall, input bit decRdy,
                                input logic [3:0] mask);
      int  pre;
      int  nEnq;
      bus.flush_i       = flush;
      bus.stall_i       = stall;
      bus.decodeReady_i = decRdy;
      for (int k = 0; k < DECODE_WIDTH; k++) begin
         bus.decodedPacket_i[k].valid   = mask[k];
         bus.decodedPacket_i[k].payload = {16'(groupId), 16'(k)};
      end
      @(negedge clk);
      checkOutput("count", int'(bus.instCount_o), modelCount);
      checkOutput("ready", int'(bus.instBufferReady_o), int'(modelCount >= 4));
      checkOutput("stallFetch", int'(bus.stallFetch_o), int'(modelCount > 28));
      @(posedge clk);
      pre = modelCount;
      if (flush) begin
         expQ.delete();
         modelCount = 0;
      end else begin
         nEnq = 0;
         if (decRdy && !(pre > 28)) begin
            for (int k = 0; k < DECODE_WIDTH; k++) begin
               if (mask[k]) begin
                  expQ.push_back(renPkt'({1'b1, 16'(groupId), 16'(k)}));
                  nEnq++;
               end
            end
         end
         modelCount = pre + nEnq - ((pre >= 4 && !stall) ? 4 : 0);
      end
      groupId++;
      #1;
   endtask

   task automatic resetPulse();
      #1;
      reset = 1'b1;
      #1;
      checkOutput("rstCount", int'(bus.instCount_o), 0);
      checkOutput("rstReady", int'(bus.instBufferReady_o), 0);
      checkOutput("rstStallFetch", int'(bus.stallFetch_o), 0);
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         checkOutput("rstValid", int'(bus.renPacket_o[i].valid), 0);
      end
      reset = 1'b0;
      expQ.delete();
      modelCount = 0;
   endtask

   // Scoreboard monitor: a presented bundle that will fire must match the oldest four packets.
   initial begin
      renPkt exp;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.instBufferReady_o) begin
               if (!bus.stall_i && !bus.flush_i) begin
                  for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                     if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL bundleUnderflow actual=bundle expected=empty at %0t", $time);
                     end else begin
                        exp = expQ.pop_front();
                        checkOutput("bundlePayload", int'(bus.renPacket_o[i].payload), int'(exp.payload));
                        checkOutput("bundleValid", int'(bus.renPacket_o[i].valid), 1);
                     end
                  end
               end
            end else begin
               for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                  checkOutput("idleValid", int'(bus.renPacket_o[i].valid), 0);
               end
            end
         end
      end
   end

   initial begin
      reset             = 1'b1;
      bus.flush_i       = 1'b0;
      bus.stall_i       = 1'b0;
      bus.decodeReady_i = 1'b0;
      bus.decodedPacket_i = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Full groups every cycle: ready from the second cycle, steady count of 4.
      for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b0, 1'b1, 4'hF);

      // Backend stalled while filling: count saturates at 32, extra groups are refused.
      for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);

      // Release with continuous refill: head and tail walk across the wrap point.
      for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b0, 1'b1, 4'hF);
      for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

      // Build count 13, then flush alongside a valid decode group.
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF);
      for (int c = 0; c < 2; c++) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

      // Build count 9, then an asynchronous reset pulse between edges.
      for (int c = 0; c < 2; c++) applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001);
      resetPulse();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

      // Sparse slots 1 and 3 twice: one compacted bundle g0s1,g0s3,g1s1,g1s3.
      for (int c = 0; c < 2; c++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b1010);
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

      checkOutput("drainEmpty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
